mux_sel_arbiter: RTL

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

---
 rtl/mux_sel_pkg.sv | 6 +
 rtl/mux_sel_arbiter_rr_pick4.sv | 22 ++
 rtl/mux_sel_arbiter.sv | 52 +++++
 3 files changed

// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg: shared lane count, lane index width and arbiter state encoding
package mux_sel_pkg;
  localparam int N_LANES = 4;
  localparam int LANE_W = 2;
  typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/mux_sel_arbiter_rr_pick4.sv
// rr_pick4: round-robin search over four lanes, starting after ptr and wrapping 3->0
module rr_pick4
  import mux_sel_pkg::*;
(
  input  logic [N_LANES-1:0] valid,
  input  logic [LANE_W-1:0]  ptr,
  output logic [LANE_W-1:0]  win,
  output logic               any
);
  logic [LANE_W-1:0]    base;
  logic [LANE_W-1:0]    off;
  logic [2*N_LANES-1:0] dbl;
  logic [N_LANES-1:0]   rot;
  always_comb begin
    base = ptr + 2'd1;
    dbl  = {valid, valid} >> base;
    rot  = dbl[N_LANES-1:0];
    off  = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    win  = base + off;
    any  = |valid;
  end
endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin 4:1 arbiter with a one-beat registered output stage and stall counter
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LANES-1:0] req_valid,
  input  logic [N_LANES-1:0] req_data,
  output logic [N_LANES-1:0] req_ready,
  output logic               s1,
  output logic               s2,
  output logic               out_valid,
  output logic               out_data,
  input  logic               out_ready,
  output logic [STALL_W-1:0] stall_cnt
);
  state_t            state, state_nxt;
  logic [LANE_W-1:0] ptr, win;
  logic              any, acc;

  rr_pick4 u_pick (.valid(req_valid), .ptr(ptr), .win(win), .any(any));

  // rst_n gates acc so no strobe leaks out while reset is held
  always_comb begin
    acc       = rst_n && (state == IDLE || out_ready) && any;
    req_ready = acc ? (N_LANES'(1) << win) : '0;
    state_nxt = acc ? HOLD : out_ready ? IDLE : state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      ptr       <= 2'd3;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == HOLD);
      if (acc) begin
        out_data <= req_data[win];
        {s2, s1} <= win;
        ptr      <= win;
      end
      if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule
